decoder_seq: RTL and testbench

Parametrised registered N-to-2^N one-hot decoder, the successor to the team's fixed 2-to-4 decoder. It adds a valid/ready input handshake, a registered output, optional active-low output polarity, and an autonomous SCAN mode. In SCAN mode the block walks the one-hot output across all lines with a programmable dwell time. It targets row/chip-select and multiplexed-display scanning, sitting between control logic and select lines.

---
 rtl/decoder_seq_pkg.sv | 22 ++
 rtl/decoder_seq_if.sv | 36 +++
 rtl/decoder_seq_onehot_dec.sv | 29 ++
 rtl/decoder_seq.sv | 124 ++++++++++++
 tb/tb_decoder_seq.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/decoder_seq_pkg.sv
`default_nettype none
// ============================================================================
// decoder_seq_pkg : shared modes, FSM states and width helper for decoder_seq
// Revision: 1.0
// ============================================================================
package decoder_seq_pkg;

    localparam logic MODE_DECODE = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEC  = 2'd1,
        SCAN = 2'd2
    } state_t;

    function automatic int out_width(input int sel_w);
        return 1 << sel_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_seq_if.sv
`default_nettype none
// ============================================================================
// decoder_seq_if : control/select bundle between controller and decoder_seq
// Revision: 1.0
// ============================================================================
interface decoder_seq_if #(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8
);
    import decoder_seq_pkg::*;

    localparam int OUT_W = out_width(SEL_W);

    logic               en;
    logic               mode;
    logic               sel_valid;
    logic [SEL_W-1:0]   sel;
    logic               sel_ready;
    logic [DWELL_W-1:0] dwell;
    logic [OUT_W-1:0]   y;
    logic               y_valid;
    logic [SEL_W-1:0]   idx;
    logic               wrap;

    modport master (
        output en, mode, sel_valid, sel, dwell,
        input  sel_ready, y, y_valid, idx, wrap
    );

    modport slave (
        input  en, mode, sel_valid, sel, dwell,
        output sel_ready, y, y_valid, idx, wrap
    );

endinterface
`default_nettype wire

// File: rtl/decoder_seq_onehot_dec.sv
`default_nettype none
// ============================================================================
// onehot_dec : combinational SEL_W -> 2**SEL_W one-hot decoder with polarity
// Revision: 1.0
// ============================================================================
module onehot_dec
    import decoder_seq_pkg::*;
#(
    parameter int SEL_W      = 2,
    parameter int ACTIVE_LOW = 0,
    localparam int OUT_W     = out_width(SEL_W)
) (
    input  logic [SEL_W-1:0] idx,
    input  logic             act,
    output logic [OUT_W-1:0] y
);

    logic [OUT_W-1:0] line;

    always_comb begin
        line = '0;
        if (act) begin
            line[idx] = 1'b1;
        end
        y = (ACTIVE_LOW != 0) ? ~line : line;
    end

endmodule
`default_nettype wire

// File: rtl/decoder_seq.sv
`default_nettype none
// ============================================================================
// decoder_seq : registered one-hot decoder with valid/ready input and SCAN walk
// Revision: 1.0
// ============================================================================
module decoder_seq
    import decoder_seq_pkg::*;
#(
    parameter int SEL_W      = 2,
    parameter int DWELL_W    = 8,
    parameter int ACTIVE_LOW = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    decoder_seq_if.slave bus
);

    localparam int OUT_W = out_width(SEL_W);
    localparam logic [OUT_W-1:0] Y_OFF = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   y_q, y_d;
    logic               y_valid_q, y_valid_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic               wrap_q, wrap_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;

    logic scan_req;
    logic xfer;

    assign scan_req      = (bus.mode == MODE_SCAN);
    assign bus.sel_ready = bus.en & ~scan_req & rst_n;
    assign xfer          = bus.sel_valid & bus.sel_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            y_q       <= Y_OFF;
            y_valid_q <= 1'b0;
            idx_q     <= '0;
            wrap_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            idx_q     <= idx_d;
            wrap_q    <= wrap_d;
            cnt_q     <= cnt_d;
        end
    end

    // A transfer outranks every mode-change path, including leaving SCAN.
    always_comb begin
        state_d = state_q;
        if (!bus.en) begin
            state_d = IDLE;
        end else if (xfer) begin
            state_d = DEC;
        end else begin
            case (state_q)
                IDLE:    if (scan_req)  state_d = SCAN;
                DEC:     if (scan_req)  state_d = IDLE;
                SCAN:    if (!scan_req) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        y_valid_d = y_valid_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        wrap_d    = 1'b0;
        if (!bus.en) begin
            y_valid_d = 1'b0;
        end else if (xfer) begin
            y_valid_d = 1'b1;
            idx_d     = bus.sel;
        end else begin
            case (state_q)
                IDLE: begin
                    y_valid_d = scan_req;
                    if (scan_req) begin
                        idx_d = '0;
                        cnt_d = bus.dwell;
                    end
                end
                DEC: begin
                    if (scan_req) y_valid_d = 1'b0;
                end
                SCAN: begin
                    if (!scan_req) begin
                        y_valid_d = 1'b0;
                    end else if (cnt_q == '0) begin
                        idx_d  = idx_q + SEL_W'(1);
                        cnt_d  = bus.dwell;
                        wrap_d = (idx_q == {SEL_W{1'b1}});
                    end else begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end
                end
                default: y_valid_d = 1'b0;
            endcase
        end
    end

    // y is rebuilt from the next index and validity, so it can never carry two lines.
    onehot_dec #(
        .SEL_W      (SEL_W),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_onehot_dec (
        .idx (idx_d),
        .act (y_valid_d),
        .y   (y_d)
    );

    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;
    assign bus.idx     = idx_q;
    assign bus.wrap    = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_decoder_seq.sv
`default_nettype none
// ============================================================================
// tb_decoder_seq : directed vector table plus hand sequences for decoder_seq
// Revision: 1.0
// ============================================================================
module tb_decoder_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    decoder_seq_if #(.SEL_W(2), .DWELL_W(8)) bus_a ();
    decoder_seq_if #(.SEL_W(3), .DWELL_W(8)) bus_b ();

    decoder_seq #(.SEL_W(2), .DWELL_W(8), .ACTIVE_LOW(0)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    decoder_seq #(.SEL_W(3), .DWELL_W(8), .ACTIVE_LOW(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       en;
        logic       mode;
        logic       v;
        logic [1:0] sel;
        logic       rdy;
        logic [3:0] y;
        logic       yv;
        logic [1:0] idx;
        logic       wrap;
    } vec_t;

    vec_t tbl[$];

    // Single-line-at-most invariant on both instances, every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            check("onehot_a", 32'($onehot0(bus_a.y)), 32'd1);
            check("onehot_b", 32'($onehot0(~bus_b.y)), 32'd1);
        end
    end

    initial begin
        bus_a.en = 1'b1; bus_a.mode = 1'b0; bus_a.sel_valid = 1'b0;
        bus_a.sel = 2'd0; bus_a.dwell = 8'd1;
        bus_b.en = 1'b0; bus_b.mode = 1'b0; bus_b.sel_valid = 1'b0;
        bus_b.sel = 3'd0; bus_b.dwell = 8'd0;

        //            en mode v  sel rdy  y        yv idx wrap
        tbl.push_back('{1, 0, 1, 2'd2, 1, 4'b0100, 1, 2'd2, 0}); // decode sel=2
        tbl.push_back('{1, 0, 0, 2'd0, 1, 4'b0100, 1, 2'd2, 0}); // hold
        tbl.push_back('{1, 0, 1, 2'd0, 1, 4'b0001, 1, 2'd0, 0}); // back-to-back
        tbl.push_back('{1, 0, 1, 2'd1, 1, 4'b0010, 1, 2'd1, 0});
        tbl.push_back('{1, 0, 1, 2'd3, 1, 4'b1000, 1, 2'd3, 0});
        tbl.push_back('{1, 0, 0, 2'd0, 1, 4'b1000, 1, 2'd3, 0});
        tbl.push_back('{0, 0, 1, 2'd1, 0, 4'b0000, 0, 2'd3, 0}); // disable keeps idx
        tbl.push_back('{1, 1, 1, 2'd2, 0, 4'b0001, 1, 2'd0, 0}); // scan entry, dwell=1
        tbl.push_back('{1, 1, 0, 2'd0, 0, 4'b0001, 1, 2'd0, 0});
        tbl.push_back('{1, 1, 0, 2'd0, 0, 4'b0010, 1, 2'd1, 0});
        tbl.push_back('{1, 1, 0, 2'd0, 0, 4'b0010, 1, 2'd1, 0});
        tbl.push_back('{1, 1, 0, 2'd0, 0, 4'b0100, 1, 2'd2, 0});
        tbl.push_back('{1, 1, 0, 2'd0, 0, 4'b0100, 1, 2'd2, 0});
        tbl.push_back('{1, 1, 0, 2'd0, 0, 4'b1000, 1, 2'd3, 0});
        tbl.push_back('{1, 1, 0, 2'd0, 0, 4'b1000, 1, 2'd3, 0});
        tbl.push_back('{1, 1, 0, 2'd0, 0, 4'b0001, 1, 2'd0, 1}); // wrap pulse
        tbl.push_back('{1, 1, 0, 2'd0, 0, 4'b0001, 1, 2'd0, 0});
        tbl.push_back('{1, 1, 0, 2'd0, 0, 4'b0010, 1, 2'd1, 0});
        tbl.push_back('{1, 1, 0, 2'd0, 0, 4'b0010, 1, 2'd1, 0});
        tbl.push_back('{1, 1, 0, 2'd0, 0, 4'b0100, 1, 2'd2, 0});
        tbl.push_back('{1, 0, 1, 2'd1, 1, 4'b0010, 1, 2'd1, 0}); // leave scan + transfer
        tbl.push_back('{1, 0, 0, 2'd0, 1, 4'b0010, 1, 2'd1, 0});
        tbl.push_back('{1, 1, 0, 2'd0, 0, 4'b0000, 0, 2'd1, 0}); // DEC->SCAN via IDLE
        tbl.push_back('{1, 1, 0, 2'd0, 0, 4'b0001, 1, 2'd0, 0});
        tbl.push_back('{1, 0, 0, 2'd0, 1, 4'b0000, 0, 2'd0, 0}); // SCAN->DEC, no transfer
        tbl.push_back('{1, 0, 0, 2'd0, 1, 4'b0000, 0, 2'd0, 0});
        tbl.push_back('{1, 0, 1, 2'd3, 1, 4'b1000, 1, 2'd3, 0});

        // Reset state
        #12;
        check("rst_y_a",     32'(bus_a.y), 32'h0);
        check("rst_yv_a",    32'(bus_a.y_valid), 32'h0);
        check("rst_idx_a",   32'(bus_a.idx), 32'h0);
        check("rst_wrap_a",  32'(bus_a.wrap), 32'h0);
        check("rst_ready_a", 32'(bus_a.sel_ready), 32'h0);
        check("rst_y_b",     32'(bus_b.y), 32'hFF);
        check("rst_yv_b",    32'(bus_b.y_valid), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        tick();

        foreach (tbl[i]) begin
            bus_a.en        = tbl[i].en;
            bus_a.mode      = tbl[i].mode;
            bus_a.sel_valid = tbl[i].v;
            bus_a.sel       = tbl[i].sel;
            #1;
            check($sformatf("vec%0d_ready", i), 32'(bus_a.sel_ready), 32'(tbl[i].rdy));
            tick();
            check($sformatf("vec%0d_y", i),    32'(bus_a.y),       32'(tbl[i].y));
            check($sformatf("vec%0d_yv", i),   32'(bus_a.y_valid), 32'(tbl[i].yv));
            check($sformatf("vec%0d_idx", i),  32'(bus_a.idx),     32'(tbl[i].idx));
            check($sformatf("vec%0d_wrap", i), 32'(bus_a.wrap),    32'(tbl[i].wrap));
        end
        bus_a.sel_valid = 1'b0;

        // Active-low, SEL_W=3 instance
        bus_b.en = 1'b1; bus_b.sel = 3'd5; bus_b.sel_valid = 1'b1;
        tick();
        bus_b.sel_valid = 1'b0;
        check("al_y",   32'(bus_b.y), 32'hDF);
        check("al_yv",  32'(bus_b.y_valid), 32'h1);
        check("al_idx", 32'(bus_b.idx), 32'h5);
        bus_b.en = 1'b0;
        tick();
        check("al_off_y",   32'(bus_b.y), 32'hFF);
        check("al_off_yv",  32'(bus_b.y_valid), 32'h0);
        check("al_off_idx", 32'(bus_b.idx), 32'h5);

        // Async reset mid-scan, then restart; dwell change lands only at reload
        bus_a.en = 1'b1; bus_a.mode = 1'b1; bus_a.dwell = 8'd0;
        tick();
        tick();
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_y",    32'(bus_a.y), 32'h0);
        check("arst_yv",   32'(bus_a.y_valid), 32'h0);
        check("arst_idx",  32'(bus_a.idx), 32'h0);
        check("arst_y_b",  32'(bus_b.y), 32'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("restart_y",    32'(bus_a.y), 32'h1);
        check("restart_yv",   32'(bus_a.y_valid), 32'h1);
        check("restart_wrap", 32'(bus_a.wrap), 32'h0);
        tick();
        check("dw0_idx1", 32'(bus_a.idx), 32'h1);
        bus_a.dwell = 8'd2;
        tick();
        check("dw2_idx2_a", 32'(bus_a.idx), 32'h2);
        tick();
        check("dw2_idx2_b", 32'(bus_a.idx), 32'h2);
        tick();
        check("dw2_idx2_c", 32'(bus_a.idx), 32'h2);
        tick();
        check("dw2_idx3",   32'(bus_a.idx), 32'h3);
        check("dw2_y3",     32'(bus_a.y), 32'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
